// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt priority controller: FSM states,
// default source count and named source slots.
package interrupt_pkg;

  localparam int NUM_SRC_DEFAULT = 4;

  localparam int SRC_KEY   = 0;
  localparam int SRC_TIMER = 1;
  localparam int SRC_UART  = 2;
  localparam int SRC_SPARE = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_edge_latch.sv
// One interrupt source: rising-edge detector feeding a sticky pending bit.
// A new edge in the same cycle as a clear keeps the bit set.
module irq_edge_latch (
  input  logic clock,
  input  logic reset,
  input  logic irq_in,
  input  logic clr,
  output logic pending
);

  logic prev_q;
  logic prev_d;
  logic pending_q;
  logic pending_d;
  logic rise;

  always_comb begin
    rise      = irq_in & ~prev_q;
    prev_d    = irq_in;
    pending_d = (pending_q & ~clr) | rise;
  end

  // History resets high so a line already asserted at reset release is not an event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q    <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/interrupt_priority_controller.sv
// Latches interrupt events per source, picks the lowest eligible index and
// runs the request / acknowledge / return handshake with the CPU.
module interrupt_priority_controller
  import interrupt_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int CODE_W  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irqIn,
  input  logic [NUM_SRC-1:0] irqMask,
  input  logic               globalEnable,
  input  logic               irqAck,
  input  logic               irqDone,
  output logic               irqOut,
  output logic [CODE_W-1:0]  irqCode,
  output logic [NUM_SRC-1:0] pendingOut,
  output irq_state_e         state_dbg
);

  // Handshake: irqOut stays high in REQUEST until the CPU pulses irqAck (taken)
  // or the latched source loses eligibility (withdrawn); irqDone in SERVICE
  // returns to IDLE. irqCode is meaningful only while irqOut is high.

  irq_state_e          state_q;
  irq_state_e          state_d;
  logic                irq_out_q;
  logic                irq_out_d;
  logic [CODE_W-1:0]   irq_code_q;
  logic [CODE_W-1:0]   irq_code_d;

  logic [NUM_SRC-1:0]  pending;
  logic [NUM_SRC-1:0]  clr;
  logic [NUM_SRC-1:0]  eligible;
  logic [CODE_W-1:0]   winner;
  logic                any_eligible;
  logic                withdraw;
  logic                take;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_latch u_latch (
      .clock   (clock),
      .reset   (reset),
      .irq_in  (irqIn[g]),
      .clr     (clr[g]),
      .pending (pending[g])
    );
  end

  always_comb begin
    take     = (state_q == REQUEST) && irqAck;
    withdraw = irqMask[irq_code_q] | ~globalEnable;
    eligible = pending & ~irqMask & {NUM_SRC{globalEnable}};
    any_eligible = |eligible;

    clr = '0;
    if (take) begin
      clr[irq_code_q] = 1'b1;
    end

    // Scan downward so the lowest set index is the one left in winner.
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = CODE_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    irq_out_d  = irq_out_q;
    irq_code_d = irq_code_q;
    case (state_q)
      IDLE: begin
        if (any_eligible) begin
          state_d    = REQUEST;
          irq_out_d  = 1'b1;
          irq_code_d = winner;
        end
      end
      REQUEST: begin
        if (take) begin
          state_d   = SERVICE;
          irq_out_d = 1'b0;
        end else if (withdraw) begin
          state_d   = IDLE;
          irq_out_d = 1'b0;
        end
      end
      SERVICE: begin
        irq_out_d = 1'b0;
        if (irqDone) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        irq_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      irq_out_q  <= 1'b0;
      irq_code_q <= '0;
    end else begin
      state_q    <= state_d;
      irq_out_q  <= irq_out_d;
      irq_code_q <= irq_code_d;
    end
  end

  assign irqOut     = irq_out_q;
  assign irqCode    = irq_code_q;
  assign pendingOut = pending;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_interrupt_priority_controller.sv
// Scoreboard bench: directed handshake scenarios plus randomized traffic,
// checked against an event-level reference model of the controller.
module tb_interrupt_priority_controller;
  import interrupt_pkg::*;

  localparam int N = 4;

  logic         clock;
  logic         reset;
  logic [N-1:0] irqIn;
  logic [N-1:0] irqMask;
  logic         globalEnable;
  logic         irqAck;
  logic         irqDone;
  logic         irqOut;
  logic [1:0]   irqCode;
  logic [N-1:0] pendingOut;
  irq_state_e   state_dbg;

  interrupt_priority_controller #(.NUM_SRC(N), .CODE_W(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .irqIn        (irqIn),
    .irqMask      (irqMask),
    .globalEnable (globalEnable),
    .irqAck       (irqAck),
    .irqDone      (irqDone),
    .irqOut       (irqOut),
    .irqCode      (irqCode),
    .pendingOut   (pendingOut),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Expected word: {irqOut, irqCode, pendingOut, state}
  logic [8:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  bit         m_prev[N];
  bit         m_pend[N];
  int         m_phase;   // 0 waiting, 1 asking CPU, 2 CPU servicing
  int         m_code;
  bit         m_out;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 1'b1;
      m_pend[i] = 1'b0;
    end
    m_phase = 0;
    m_code  = 0;
    m_out   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int win;
    bit taken;
    win = -1;
    if (globalEnable) begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i] && !irqMask[i]) begin
          win = i;
          break;
        end
      end
    end
    taken = (m_phase == 1) && irqAck;
    if (taken) m_pend[m_code] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (irqIn[i] && !m_prev[i]) m_pend[i] = 1'b1;
      m_prev[i] = irqIn[i];
    end
    if (m_phase == 0) begin
      if (win >= 0) begin
        m_phase = 1;
        m_out   = 1'b1;
        m_code  = win;
      end
    end else if (m_phase == 1) begin
      if (taken) begin
        m_phase = 2;
        m_out   = 1'b0;
      end else if (irqMask[m_code] || !globalEnable) begin
        m_phase = 0;
        m_out   = 1'b0;
      end
    end else begin
      if (irqDone) m_phase = 0;
    end
  endtask

  function automatic logic [8:0] model_word();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_pend[i];
    return {m_out, 2'(m_code), p, 2'(m_phase)};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [N-1:0] in_v, input logic [N-1:0] mask_v,
                       input logic ge_v, input logic ack_v, input logic done_v);
    irqIn        = in_v;
    irqMask      = mask_v;
    globalEnable = ge_v;
    irqAck       = ack_v;
    irqDone      = done_v;
    model_step();
    exp_q.push_back(model_word());
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clock) begin
    logic [8:0] exp_w;
    logic [8:0] act_w;
    #1;
    if (reset && exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      act_w = {irqOut, irqCode, pendingOut, 2'(state_dbg)};
      n_cmp++;
      if (act_w !== exp_w) begin
        n_err++;
        $display("FAIL scoreboard t=%0t: got out=%b code=%0d pend=%b st=%0d, expected out=%b code=%0d pend=%b st=%0d",
                 $time, act_w[8], act_w[7:6], act_w[5:2], act_w[1:0],
                 exp_w[8], exp_w[7:6], exp_w[5:2], exp_w[1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] cur_in;
    logic [N-1:0] cur_mask;

    irqIn = '0; irqMask = '0; globalEnable = 1'b1; irqAck = 1'b0; irqDone = 1'b0;
    reset = 1'b0;
    m_reset();
    #1;
    check("reset_values", {irqOut, irqCode, pendingOut, 2'(state_dbg)}, 9'd0);
    @(negedge clock);
    reset = 1'b1;

    // 1: single source, full handshake
    drive(4'b0100, 4'b0000, 1, 0, 0);
    drive(4'b0100, 4'b0000, 1, 0, 0);
    drive(4'b0100, 4'b0000, 1, 1, 0);
    drive(4'b0100, 4'b0000, 1, 0, 0);
    drive(4'b0100, 4'b0000, 1, 0, 1);
    drive(4'b0000, 4'b0000, 1, 0, 0);

    // 2: simultaneous sources, priority then the remaining one
    drive(4'b1010, 4'b0000, 1, 0, 0);
    drive(4'b1010, 4'b0000, 1, 0, 0);
    drive(4'b1010, 4'b0000, 1, 1, 0);
    drive(4'b1010, 4'b0000, 1, 0, 1);
    drive(4'b1010, 4'b0000, 1, 0, 0);
    drive(4'b1010, 4'b0000, 1, 1, 0);
    drive(4'b0000, 4'b0000, 1, 0, 1);
    drive(4'b0000, 4'b0000, 1, 0, 0);

    // 3: masked source stays pending, request once unmasked
    drive(4'b0001, 4'b0001, 1, 0, 0);
    drive(4'b0001, 4'b0001, 1, 0, 0);
    drive(4'b0001, 4'b0001, 1, 0, 0);
    drive(4'b0001, 4'b0000, 1, 0, 0);
    drive(4'b0001, 4'b0000, 1, 0, 0);
    drive(4'b0001, 4'b0000, 1, 1, 0);
    drive(4'b0000, 4'b0000, 1, 0, 1);

    // 4: global enable withdraw keeps pending, re-enable requests again
    drive(4'b0100, 4'b0000, 1, 0, 0);
    drive(4'b0100, 4'b0000, 1, 0, 0);
    drive(4'b0100, 4'b0000, 0, 0, 0);
    drive(4'b0100, 4'b0000, 0, 0, 0);
    drive(4'b0100, 4'b0000, 1, 0, 0);
    drive(4'b0100, 4'b0000, 1, 0, 0);
    drive(4'b0100, 4'b0000, 0, 1, 0);
    drive(4'b0000, 4'b0000, 1, 0, 1);

    // 5: new edge on the acked source in the ack cycle survives
    drive(4'b0010, 4'b0000, 1, 0, 0);
    drive(4'b0000, 4'b0000, 1, 0, 0);
    drive(4'b0010, 4'b0000, 1, 1, 0);
    drive(4'b0010, 4'b0000, 1, 1, 0);
    drive(4'b0010, 4'b0000, 1, 0, 1);
    drive(4'b0010, 4'b0000, 1, 0, 0);
    drive(4'b0010, 4'b0000, 1, 1, 0);
    drive(4'b0000, 4'b0000, 1, 0, 1);

    // 6: async reset mid-request, held-high line across release
    drive(4'b0100, 4'b0000, 1, 0, 0);
    drive(4'b0100, 4'b0000, 1, 0, 0);
    irqIn = 4'b0101;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_out", {irqOut, irqCode, pendingOut, 2'(state_dbg)}, 9'd0);
    m_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    drive(4'b0101, 4'b0000, 1, 0, 0);
    drive(4'b0101, 4'b0000, 1, 0, 0);
    drive(4'b0101, 4'b0000, 1, 0, 0);
    drive(4'b0000, 4'b0000, 1, 0, 0);

    // randomized traffic, including ack/done pulses in every phase
    cur_in = '0;
    for (int c = 0; c < 800; c++) begin
      cur_in = cur_in ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      cur_mask = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      drive(cur_in, cur_mask, ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end
    drive(4'b0000, 4'b0000, 1, 0, 0);

    repeat (4) @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
